// File: rtl/pio_in_edge_capture.sv
// Avalon-MM input PIO: synchronised inputs, per-bit sticky edge capture with
// masked level IRQ, and a strobe-triggered snapshot with valid/overrun flags.
module pio_in_edge_capture #(
   parameter int unsigned          DATA_WIDTH  = 16,
   parameter int unsigned          SYNC_STAGES = 2,
   parameter int unsigned          EDGE_MODE   = 0,
   parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [2:0]            address,
   input  logic                  chipselect,
   input  logic                  write_n,
   input  logic [31:0]           writedata,
   input  logic [DATA_WIDTH-1:0] in_port,
   input  logic                  sample_strobe,
   output logic [31:0]           readdata,
   output logic                  irq
);

   localparam logic [2:0] PRIME_DONE = 3'(SYNC_STAGES + 1);

   logic [SYNC_STAGES-1:0][DATA_WIDTH-1:0] sync_q;
   logic [DATA_WIDTH-1:0] sync_in, prev_q;
   logic [DATA_WIDTH-1:0] edge_q, edge_d, mask_q, mask_d, snap_q, snap_d;
   logic [DATA_WIDTH-1:0] edge_sel, wdata;
   logic                  valid_q, valid_d, ovr_q, ovr_d, irq_q;
   logic [2:0]            prime_q, prime_d;
   logic [31:0]           rdata_q, rdata_d;
   logic                  rd, wr, edge_en, snap_rd;

   assign sync_in = sync_q[SYNC_STAGES-1];
   assign rd      = chipselect & write_n;
   assign wr      = chipselect & ~write_n;
   assign snap_rd = rd && (address == 3'd4);
   assign wdata   = writedata[DATA_WIDTH-1:0];
   // Edges are ignored until the synchroniser and prev_q hold real samples.
   assign edge_en = (prime_q == PRIME_DONE);

   always_comb begin
      case (EDGE_MODE)
         0:       edge_sel = sync_in & ~prev_q;
         1:       edge_sel = ~sync_in & prev_q;
         default: edge_sel = sync_in ^ prev_q;
      endcase
   end

   always_comb begin
      prime_d = edge_en ? prime_q : prime_q + 3'd1;
      mask_d  = (wr && address == 3'd2) ? wdata : mask_q;
      // A new edge wins over a coincident W1C clear.
      edge_d  = (edge_q & ~((wr && address == 3'd3) ? wdata : '0))
              | (edge_en ? edge_sel : '0);
      snap_d  = sample_strobe ? sync_in : snap_q;
      valid_d = sample_strobe ? 1'b1 : (snap_rd ? 1'b0 : valid_q);
      ovr_d   = (ovr_q & ~(wr && address == 3'd5 && writedata[1]))
              | (sample_strobe & valid_q & ~snap_rd);
      rdata_d = rdata_q;
      if (rd) begin
         rdata_d = '0;
         case (address)
            3'd0:    rdata_d[DATA_WIDTH-1:0] = sync_in;
            3'd2:    rdata_d[DATA_WIDTH-1:0] = mask_q;
            3'd3:    rdata_d[DATA_WIDTH-1:0] = edge_q;
            3'd4:    rdata_d[DATA_WIDTH-1:0] = snap_q;
            3'd5:    rdata_d[1:0] = {ovr_q, valid_q};
            default: rdata_d = '0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q  <= '0;
         prev_q  <= '0;
         prime_q <= '0;
         edge_q  <= '0;
         mask_q  <= RESET_VALUE;
         snap_q  <= '0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
         irq_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         sync_q[0] <= in_port;
         for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
         prev_q  <= sync_in;
         prime_q <= prime_d;
         edge_q  <= edge_d;
         mask_q  <= mask_d;
         snap_q  <= snap_d;
         valid_q <= valid_d;
         ovr_q   <= ovr_d;
         irq_q   <= |(edge_q & mask_q);
         rdata_q <= rdata_d;
      end
   end

   assign readdata = rdata_q;
   assign irq      = irq_q;

endmodule

// File: tb/tb_pio_in_edge_capture.sv
// Directed bench for pio_in_edge_capture (16-bit, 2 sync stages, rising edges).
module tb_pio_in_edge_capture;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [2:0]  address;
   logic        chipselect, write_n, sample_strobe;
   logic [31:0] writedata, readdata, rd;
   logic [15:0] in_port;
   logic        irq;
   int          errors = 0, checks = 0;

   always #5 clk = ~clk;

   pio_in_edge_capture #(.DATA_WIDTH(16), .SYNC_STAGES(2), .EDGE_MODE(0),
                         .RESET_VALUE(16'h0)) dut (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .in_port(in_port),
      .sample_strobe(sample_strobe), .readdata(readdata), .irq(irq));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic rd_reg(input logic [2:0] a, output logic [31:0] d);
      chipselect = 1'b1; write_n = 1'b1; address = a;
      @(posedge clk); #1;
      chipselect = 1'b0; d = readdata;
   endtask

   task automatic wr_reg(input logic [2:0] a, input logic [31:0] d);
      chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
      @(posedge clk); #1;
      chipselect = 1'b0; write_n = 1'b1;
   endtask

   initial begin
      reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1; address = '0;
      writedata = '0; sample_strobe = 1'b0; in_port = 16'hFFFF;
      #22;
      check("rst_readdata", readdata, 32'h0);
      check("rst_irq", {31'b0, irq}, 32'h0);
      @(posedge clk); #1; reset_n = 1'b1;

      // Inputs already high at reset release must not look like edges.
      for (int i = 0; i < 20; i++) begin
         tick(1);
         check("prime_irq", {31'b0, irq}, 32'h0);
      end
      rd_reg(3'd3, rd); check("prime_edge", rd, 32'h0);

      in_port = 16'h0000; tick(5);
      in_port = 16'h0005; tick(4);
      rd_reg(3'd0, rd); check("data_5", rd, 32'h5);
      rd_reg(3'd3, rd); check("edge_5", rd, 32'h5);
      wr_reg(3'd3, 32'h5);
      rd_reg(3'd3, rd); check("edge_clr", rd, 32'h0);

      // Masked rising edge on bit 2.
      wr_reg(3'd2, 32'h4);
      in_port = 16'h0000; tick(5);
      in_port = 16'h0004; tick(4);
      check("irq_bit2", {31'b0, irq}, 32'h1);
      rd_reg(3'd3, rd); check("edge_bit2", rd, 32'h4);
      wr_reg(3'd3, 32'h4);
      tick(1);
      check("irq_clr", {31'b0, irq}, 32'h0);
      rd_reg(3'd3, rd); check("edge_bit2_clr", rd, 32'h0);

      // Unmasked edge on bit 0, then enable mask.
      wr_reg(3'd2, 32'h0);
      in_port = 16'h0005; tick(4);
      check("irq_unmasked", {31'b0, irq}, 32'h0);
      rd_reg(3'd3, rd); check("edge_bit0", rd, 32'h1);
      wr_reg(3'd2, 32'h1);
      tick(1);
      check("irq_mask_on", {31'b0, irq}, 32'h1);
      wr_reg(3'd2, 32'h0);
      wr_reg(3'd3, 32'hFFFF);

      // Two strobes without a read: overrun.
      in_port = 16'h1234; tick(3);
      sample_strobe = 1'b1; tick(1); sample_strobe = 1'b0;
      in_port = 16'h5678; tick(3);
      sample_strobe = 1'b1; tick(1); sample_strobe = 1'b0;
      rd_reg(3'd5, rd); check("status_ovr", rd, 32'h3);
      rd_reg(3'd4, rd); check("snap_5678", rd, 32'h5678);
      rd_reg(3'd5, rd); check("status_rdclr", rd, 32'h2);
      wr_reg(3'd5, 32'h2);
      rd_reg(3'd5, rd); check("status_ovrclr", rd, 32'h0);

      // Strobe coincident with snapshot read.
      sample_strobe = 1'b1; tick(1); sample_strobe = 1'b0;
      in_port = 16'h9ABC; tick(3);
      sample_strobe = 1'b1; rd_reg(3'd4, rd); sample_strobe = 1'b0;
      check("snap_old", rd, 32'h5678);
      rd_reg(3'd5, rd); check("status_same", rd, 32'h1);
      rd_reg(3'd4, rd); check("snap_new", rd, 32'h9ABC);

      // Width and unmapped address.
      wr_reg(3'd2, 32'hFFFF_FFFF);
      rd_reg(3'd2, rd); check("mask_width", rd, 32'h0000_FFFF);
      rd_reg(3'd1, rd); check("unmapped", rd, 32'h0);
      wr_reg(3'd2, 32'h0);

      // W1C coincident with a rising edge on bit 3.
      in_port = 16'h0000; tick(4);
      wr_reg(3'd3, 32'hFFFF);
      rd_reg(3'd3, rd); check("edge_pre_w1c", rd, 32'h0);
      in_port = 16'h0008; tick(2);
      wr_reg(3'd3, 32'h8);
      rd_reg(3'd3, rd); check("w1c_set_wins", rd, 32'h8);

      // Mid-operation reset.
      wr_reg(3'd2, 32'h8); tick(1);
      check("irq_pre_rst", {31'b0, irq}, 32'h1);
      reset_n = 1'b0; #1;
      check("midrst_irq", {31'b0, irq}, 32'h0);
      check("midrst_rd", readdata, 32'h0);
      @(posedge clk); #1; reset_n = 1'b1;
      rd_reg(3'd2, rd); check("midrst_mask", rd, 32'h0);
      rd_reg(3'd3, rd); check("midrst_edge", rd, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pio_in_edge_capture.md
Name: pio_in_edge_capture

Overview:
Parametrised Avalon-MM slave input PIO, the successor to the fixed 16-bit, read-only input port used for ADC serial-data capture. It adds:
- configurable data width;
- input synchroniser;
- per-bit edge-capture register with interrupt mask and IRQ output;
- strobe-triggered snapshot register with valid and overrun flags.

It sits between external ADC/GPIO pins and the Nios II data master. Register reads have 1-cycle latency.

Parameters:
- DATA_WIDTH, 16, input port width (1..32)
- SYNC_STAGES, 2, synchroniser flops per bit (2..4)
- EDGE_MODE, 0, edge type captured: 0 rising, 1 falling, 2 any
- RESET_VALUE, 0, reset value of irq_mask

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- address  in  3  register word address
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe (valid with chipselect)
- writedata  in  32  write data
- in_port  in  DATA_WIDTH  asynchronous external inputs
- sample_strobe  in  1  single-cycle clk-synchronous snapshot request
- readdata  out  32  registered read data
- irq  out  1  level interrupt, active high

Behaviour:
- Reset, asynchronous on reset_n=0:
  - readdata=0, irq=0.
  - Synchroniser flops 0, edge_capture 0, irq_mask=RESET_VALUE.
  - snapshot 0, valid 0, overrun 0.
  - Prime counter 0.
- Synchroniser:
  - in_port passes through SYNC_STAGES flops to give sync_in.
  - prev_in is a one-cycle-delayed sync_in.
  - Register data reflects in_port with SYNC_STAGES cycles of latency.
- Prime counter:
  - Edge detection is disabled until SYNC_STAGES+1 clk cycles after reset deassertion.
  - This suppresses spurious edges from flops leaving reset. The counter saturates and then stays enabled.
- Edge detect per bit:
  - rise = sync_in & ~prev_in; fall = ~sync_in & prev_in.
  - The selected edge per EDGE_MODE sets the corresponding edge_capture bit (sticky).
- Register map (read mux registered: readdata updates on the clk edge after the read cycle; unused bits read 0; unmapped addresses read 0 and ignore writes):
  - 0 DATA (RO): sync_in.
  - 2 IRQ_MASK (RW): bits [DATA_WIDTH-1:0].
  - 3 EDGE_CAPTURE (RW1C): write 1 clears a bit.
  - 4 SNAPSHOT (RO): data latched by sample_strobe. Reading clears valid.
  - 5 STATUS: bit0 valid (RO), bit1 overrun. Writing 1 to bit1 clears overrun.
- Read side effect: a valid read cycle is chipselect=1, write_n=1. A read at address 4 clears valid on that same edge.
- irq = |(edge_capture & irq_mask), registered (1 cycle after the capture bit sets).
- Snapshot behaviour:
  - sample_strobe=1 loads snapshot with sync_in and sets valid.
  - If valid was already 1 and no read of address 4 occurs that cycle, overrun is set.
- Simultaneous events:
  - W1C clear and new edge on the same bit in the same cycle: the bit stays 1 (set wins).
  - Strobe and snapshot read in the same cycle: readdata returns the old snapshot, the new value is latched, valid stays 1, no overrun.
  - Overrun-clear write and an overrun-setting strobe in the same cycle: overrun stays 1.
- DATA_WIDTH<32: writedata upper bits are ignored; readdata upper bits are 0.
- Reset mid-operation: all state returns to reset values immediately, and the prime counter restarts.

Test Plan:
- Reset release with in_port=16'hFFFF, EDGE_MODE=0 -> EDGE_CAPTURE reads 0 and irq stays 0 for 20 cycles.
- in_port 16'h0000 -> 16'h0005, then read address 0 after SYNC_STAGES+2 cycles -> readdata=32'h0000_0005.
- EDGE_MODE=0, mask=16'h0004, rising edge on bit2:
  - EDGE_CAPTURE=32'h4 and irq=1.
  - Write 32'h4 to address 3 -> EDGE_CAPTURE=0, irq=0 next cycle.
- Rising edge on bit0 with mask=0 -> EDGE_CAPTURE bit0=1, irq stays 0. Then write mask=1 -> irq=1.
- Two strobes with in_port 16'h1234 then 16'h5678, no read between:
  - STATUS=32'h3, SNAPSHOT reads 32'h5678, then STATUS=32'h2.
  - Write 32'h2 to address 5 -> STATUS=0.
- W1C write of bit3 coincident with a synchronised rising edge on bit3 -> EDGE_CAPTURE bit3 remains 1.
